// File: rtl/adder_avalon_driver.sv
// adder_avalon_driver: Avalon-MM host that feeds one operand pair at a time to
// the Avalon adder slave and returns its sum on a valid/ready result stream.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b   operand stream (a -> addr 0, b -> addr 1)
//   avm_write/avm_address/avm_writedata      write command to the adder
//   avm_readdata/avm_response/avm_writeresponsevalid/avm_done  adder status
//   out_valid/out_ready/out_sum/out_err      result stream
//   op_count                      number of result handshakes, wraps
//
// Every output is a flop loaded from the next-state decode, so each output
// follows the registered state and nothing depends combinationally on
// in_valid or out_ready.
module adder_avalon_driver #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              avm_write,
  output logic [1:0]        avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic [1:0]        avm_response,
  input  logic              avm_writeresponsevalid,
  input  logic              avm_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_P1 = 3'd1,
    S_WR_P2 = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] b_q;
  logic              err_q;
  logic [TMR_W-1:0]  timer_q;

  logic              accept_c;
  logic              err_set_c;
  logic              timeout_c;

  logic              in_ready_d;
  logic              avm_write_d;
  logic [1:0]        avm_address_d;
  logic [DATA_W-1:0] avm_writedata_d;
  logic              out_valid_d;

  // in_ready is a flop, so this also blocks acceptance in the first cycle after reset
  assign accept_c  = (state_q == S_IDLE) && in_valid && in_ready;
  assign err_set_c = ((state_q == S_WR_P2) || (state_q == S_WAIT)) &&
                     avm_writeresponsevalid && (avm_response != 2'b00);
  assign timeout_c = (state_q == S_WAIT) && !avm_done && (timer_q == TMR_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_c) state_d = S_WR_P1;
      S_WR_P1: state_d = S_WR_P2;
      S_WR_P2: state_d = S_WAIT;
      S_WAIT:  if (avm_done || timeout_c) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state being entered; registered below
  always_comb begin
    in_ready_d      = 1'b0;
    avm_write_d     = 1'b0;
    avm_address_d   = 2'd0;
    avm_writedata_d = '0;
    out_valid_d     = 1'b0;
    unique case (state_d)
      S_IDLE:  in_ready_d = 1'b1;
      S_WR_P1: begin
        avm_write_d     = 1'b1;
        avm_writedata_d = in_a;   // WR_P1 is only entered from the accept edge
      end
      S_WR_P2: begin
        avm_write_d     = 1'b1;
        avm_address_d   = 2'd1;
        avm_writedata_d = b_q;
      end
      S_OUT:   out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= 2'd0;
      avm_writedata <= '0;
      out_valid     <= 1'b0;
    end else begin
      in_ready      <= in_ready_d;
      avm_write     <= avm_write_d;
      avm_address   <= avm_address_d;
      avm_writedata <= avm_writedata_d;
      out_valid     <= out_valid_d;
    end
  end

  // Operand, error latch, wait timer, result capture and handoff counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_q      <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      out_sum  <= '0;
      out_err  <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept_c) begin
        b_q   <= in_b;
        err_q <= 1'b0;
      end else if (err_set_c) begin
        err_q <= 1'b1;
      end

      if (state_q == S_WR_P2) begin
        timer_q <= '0;
      end else if ((state_q == S_WAIT) && !avm_done && !timeout_c) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      if ((state_q == S_WAIT) && avm_done) begin
        out_sum <= avm_readdata;
        // a bad response arriving alongside done is still reported
        out_err <= err_q | err_set_c;
      end else if (timeout_c) begin
        out_sum <= '0;
        out_err <= 1'b1;
      end

      if ((state_q == S_OUT) && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_avalon_driver.sv
// Directed bench for adder_avalon_driver with a behavioural Avalon adder model.
module tb_adder_avalon_driver;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic              avm_write;
  logic [1:0]        avm_address;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic [1:0]        avm_response;
  logic              avm_writeresponsevalid;
  logic              avm_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_err;
  logic [CNT_W-1:0]  op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_avalon_driver #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .avm_write(avm_write), .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_response(avm_response),
    .avm_writeresponsevalid(avm_writeresponsevalid), .avm_done(avm_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .op_count(op_count)
  );

  // Adder slave model: done clears on any write, rises one cycle after the p2 write
  bit                m_no_done;
  bit                m_bad_resp;
  logic [DATA_W-1:0] m_p1, m_p2;
  logic              m_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p1 <= '0; m_p2 <= '0; m_pend <= 1'b0;
      avm_done <= 1'b0; avm_readdata <= '0;
      avm_writeresponsevalid <= 1'b0; avm_response <= 2'b00;
    end else begin
      avm_writeresponsevalid <= avm_write;
      avm_response <= (avm_write && avm_address == 2'd1 && m_bad_resp) ? 2'b10 : 2'b00;
      if (avm_write) begin
        avm_done <= 1'b0;
        if (avm_address == 2'd0) m_p1 <= avm_writedata;
        else begin
          m_p2   <= avm_writedata;
          m_pend <= 1'b1;
        end
      end else if (m_pend) begin
        m_pend <= 1'b0;
        if (!m_no_done) begin
          avm_done     <= 1'b1;
          avm_readdata <= m_p1 + m_p2;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake one operand pair, check the adder writes, wait for out_valid.
  // lat counts negedges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("wr_p1", {31'd0, avm_write, 30'd0, avm_address},
                          {31'd0, 1'b1, 32'd0}) ;
      if (lat == 1) check("wr_p1_data", 64'(avm_writedata), 64'(a));
      if (lat == 2) check("wr_p2", {31'd0, avm_write, 30'd0, avm_address},
                          {31'd0, 1'b1, 30'd0, 2'd1});
      if (lat == 2) check("wr_p2_data", 64'(avm_writedata), 64'(b));
      if (lat == 3) check("wr_idle", 64'(avm_write), 64'd0);
    end while (!out_valid && lat < 40);
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a, b, sum;
    logic        err;
    bit          no_done, bad_resp;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [CNT_W-1:0] exp_cnt;

    vecs[0] = '{32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 5};
    vecs[1] = '{32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  1'b0, 1'b0, 1'b0, 5};
    vecs[2] = '{32'd0,          32'd0,          32'd0,          1'b0, 1'b0, 1'b0, 5};
    vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'd0,          1'b0, 1'b0, 1'b0, 5};
    vecs[4] = '{32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1'b0, 11};
    vecs[5] = '{32'd10,         32'd20,         32'd30,         1'b1, 1'b0, 1'b1, 5};
    vecs[6] = '{32'h1234_5678,  32'h9ABC_DEF0,  32'hACF1_3568,  1'b0, 1'b0, 1'b0, 5};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    m_no_done = 1'b0; m_bad_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_op_count",  64'(op_count),  64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    exp_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      m_no_done  = vecs[i].no_done;
      m_bad_resp = vecs[i].bad_resp;
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_sum", i), 64'(out_sum), 64'(vecs[i].sum));
      check($sformatf("v%0d_err", i), 64'(out_err), 64'(vecs[i].err));
      check($sformatf("v%0d_in_ready_busy", i), 64'(in_ready), 64'd0);
      @(negedge clk);
      exp_cnt++;
      check($sformatf("v%0d_op_count", i), 64'(op_count), 64'(exp_cnt));
      check($sformatf("v%0d_out_drop", i), 64'(out_valid), 64'd0);
    end
    m_no_done = 1'b0; m_bad_resp = 1'b0;

    // Backpressure: result held with no adder traffic, then exactly one handoff
    out_ready = 1'b0;
    run_op(32'd100, 32'd23, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {out_valid, out_err, in_ready, avm_write, 28'd0, out_sum},
            {1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 32'd123});
    end
    check("bp_count_held", 64'(op_count), 64'(exp_cnt));
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_count", 64'(op_count), 64'(exp_cnt));
    repeat (3) @(negedge clk);
    check("bp_single_handoff", 64'(op_count), 64'(exp_cnt));

    // Reset while waiting for done: aborted op produces nothing
    while (!in_ready) @(negedge clk);
    in_a = 32'd50; in_b = 32'd50; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_op_count",  64'(op_count),  64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), 64'(out_valid), 64'd0);
    end
    run_op(32'd1, 32'd1, lat);
    check("post_abort_latency", 64'(lat), 64'd5);
    check("post_abort_sum", 64'(out_sum), 64'd2);
    check("post_abort_err", 64'(out_err), 64'd0);
    @(negedge clk);
    check("post_abort_count", 64'(op_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
